// File: rtl/maze_pkg.sv
// Shared types and constants for the maze command path (cmd_assembler, cmd_proc).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package maze_pkg;

  // Receive framing: waiting for the high byte, or holding it and waiting for the low byte
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } rx_state_t;

  // Transmit side: UART idle, or one acknowledge byte in flight
  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  // Acknowledge byte returned to the host for each response request
  localparam logic [7:0] RESP_ACK = 8'hA5;

endpackage

// File: rtl/resp_sender.sv
// Issues one UART transmit of RESP_BYTE per send_resp, queuing at most one request behind the one in flight.
// Latency: trmt in the same cycle as send_resp when idle, or in the tx_done cycle for a queued request.
// Backpressure: tx_done gates further transmits; requests beyond the single queued one are dropped.
module resp_sender
  import maze_pkg::*;
#(
  parameter logic [7:0] RESP_BYTE = RESP_ACK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_resp,
  input  logic       tx_done,
  output logic       trmt,
  output logic [7:0] tx_data,
  output logic       resp_busy
);

  tx_state_t r_state;
  tx_state_t w_state_nxt;
  logic      r_pend;
  logic      w_pend_nxt;
  logic      w_trmt;

  // State register and the one-deep pending flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TX_IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Next-state and transmit-start decode
  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend;
    w_trmt      = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (send_resp) begin
          w_trmt      = 1'b1;
          w_state_nxt = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          if (r_pend) begin
            // Launch the queued byte; a request arriving now takes the freed slot
            w_trmt     = 1'b1;
            w_pend_nxt = send_resp;
          end else if (send_resp) begin
            // Back-to-back: the new request starts as the old one finishes
            w_trmt = 1'b1;
          end else begin
            w_state_nxt = TX_IDLE;
          end
        end else if (send_resp) begin
          // Saturating: a second queued request is simply dropped
          w_pend_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = TX_IDLE;
        w_pend_nxt  = 1'b0;
      end
    endcase
  end

  assign trmt      = w_trmt & ~rst;
  assign tx_data   = RESP_BYTE;
  assign resp_busy = (r_state == TX_BUSY) | r_pend;

endmodule

// File: rtl/cmd_assembler.sv
// Frames two UART bytes (high first) into a 16-bit command and returns an acknowledge byte on request.
// Latency: clr_rx_rdy same cycle as rx_rdy; cmd/cmd_rdy valid the cycle after the low byte is accepted.
// Backpressure: cmd_rdy held until clr_cmd_rdy or a new high byte; every presented byte is accepted at once.
module cmd_assembler
  import maze_pkg::*;
#(
  parameter logic [7:0] RESP_BYTE   = RESP_ACK,
  parameter int         TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        resp_busy,
  output logic        frame_err
);

  // Timer only has to reach TIMEOUT_CYC-1, where the frame is abandoned, so it never wraps
  localparam int            TW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

  rx_state_t      r_rx_state;
  rx_state_t      w_rx_nxt;
  logic [TW-1:0]  r_timer;
  logic [TW-1:0]  w_timer_nxt;
  logic [7:0]     r_hi_byte;
  logic [15:0]    r_cmd;
  logic           r_cmd_rdy;
  logic           w_clr_rx;
  logic           w_frame_err;
  logic           w_hi_ld;
  logic           w_lo_done;

  // Receive state and inter-byte timer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= WAIT_HI;
      r_timer    <= '0;
    end else begin
      r_rx_state <= w_rx_nxt;
      r_timer    <= w_timer_nxt;
    end
  end

  // Byte acceptance and timeout decode; a byte in the timeout cycle wins over the timeout
  always_comb begin
    w_rx_nxt    = r_rx_state;
    w_timer_nxt = '0;
    w_clr_rx    = 1'b0;
    w_frame_err = 1'b0;
    w_hi_ld     = 1'b0;
    w_lo_done   = 1'b0;
    case (r_rx_state)
      WAIT_HI: begin
        if (rx_rdy) begin
          w_clr_rx = 1'b1;
          w_hi_ld  = 1'b1;
          w_rx_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (rx_rdy) begin
          w_clr_rx  = 1'b1;
          w_lo_done = 1'b1;
          w_rx_nxt  = WAIT_HI;
        end else if (r_timer == TMAX) begin
          w_frame_err = 1'b1;
          w_rx_nxt    = WAIT_HI;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: begin
        w_rx_nxt = WAIT_HI;
      end
    endcase
  end

  // Holding register for the high byte; cleared when a partial frame is abandoned
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_byte <= 8'h00;
    end else if (w_hi_ld) begin
      r_hi_byte <= rx_data;
    end else if (w_frame_err) begin
      r_hi_byte <= 8'h00;
    end
  end

  // Command register and ready flag: completion sets and beats any clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
    end else if (w_lo_done) begin
      r_cmd     <= {r_hi_byte, rx_data};
      r_cmd_rdy <= 1'b1;
    end else if (w_hi_ld || clr_cmd_rdy) begin
      r_cmd_rdy <= 1'b0;
    end
  end

  assign clr_rx_rdy = w_clr_rx & ~rst;
  assign frame_err  = w_frame_err & ~rst;
  assign cmd        = r_cmd;
  assign cmd_rdy    = r_cmd_rdy;

  resp_sender #(
    .RESP_BYTE (RESP_BYTE)
  ) u_resp_sender (
    .clk       (clk),
    .rst       (rst),
    .send_resp (send_resp),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .resp_busy (resp_busy)
  );

endmodule

// File: tb/tb_cmd_assembler.sv
// Bench for cmd_assembler: directed scenarios then random traffic, checked by a scoreboard.
// Latency: reference model predicts each pulse and register change to the exact cycle.
// Backpressure: a UART stand-in answers every trmt with tx_done after a configurable delay.
module tb_cmd_assembler;

  localparam int         T    = 16;
  localparam logic [7:0] RESP = 8'hA5;

  typedef struct {
    int   cyc;
    logic clr;
    logic ferr;
    logic trmt;
  } pulse_t;

  typedef struct {
    int          cyc;
    logic [15:0] cmd;
    logic        rdy;
    logic        busy;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        resp_busy;
  logic        frame_err;

  int     cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  bit     mon_en = 1'b0;
  int     tx_lat_lo = 1;
  int     tx_lat_hi = 4;
  pulse_t pq[$];
  snap_t  sq[$];

  cmd_assembler #(
    .RESP_BYTE   (RESP),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .trmt        (trmt),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .resp_busy   (resp_busy),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: bytes pair up by arrival order, a held high byte expires T cycles after
  // it arrived, and responses are tracked as a count of outstanding bytes (at most two).
  initial begin
    logic [15:0] m_cmd, n_cmd;
    logic        m_rdy, n_rdy;
    logic        have_hi;
    logic [7:0]  hi;
    int          hi_cyc;
    int          o, no;
    bit          d;
    logic        e_clr, e_ferr, e_trmt;
    m_cmd = 16'h0; m_rdy = 1'b0; have_hi = 1'b0; hi = 8'h0; hi_cyc = 0; o = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_clr = 1'b0; e_ferr = 1'b0; e_trmt = 1'b0;
        n_cmd = 16'h0; n_rdy = 1'b0; have_hi = 1'b0; no = 0;
      end else begin
        e_clr  = rx_rdy;
        e_ferr = 1'b0;
        n_cmd  = m_cmd;
        n_rdy  = m_rdy;
        if (clr_cmd_rdy) n_rdy = 1'b0;
        if (rx_rdy) begin
          if (!have_hi) begin
            hi = rx_data; have_hi = 1'b1; hi_cyc = cyc; n_rdy = 1'b0;
          end else begin
            n_cmd = {hi, rx_data}; n_rdy = 1'b1; have_hi = 1'b0;
          end
        end else if (have_hi && (cyc - hi_cyc == T)) begin
          e_ferr = 1'b1; have_hi = 1'b0;
        end
        d  = tx_done && (o > 0);
        no = o - (d ? 1 : 0);
        if (send_resp && no < 2) no++;
        e_trmt = (d && no >= 1) || (o == 0 && no == 1);
      end
      if (e_clr || e_ferr || e_trmt) pq.push_back('{cyc, e_clr, e_ferr, e_trmt});
      if ({n_cmd, n_rdy, no > 0} != {m_cmd, m_rdy, o > 0})
        sq.push_back('{cyc + 1, n_cmd, n_rdy, no > 0});
      m_cmd = n_cmd; m_rdy = n_rdy; o = no;
    end
  end

  // Monitor: pops expected pulses and register changes as the DUT shows them
  initial begin
    logic [2:0]  dut_p;
    logic [17:0] dut_s;
    logic [17:0] last_obs;
    pulse_t      pe;
    snap_t       se;
    last_obs = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!mon_en) begin
        last_obs = '0;
      end else begin
        while (pq.size() > 0 && pq[0].cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL pulse_missed: expected {clr,ferr,trmt}=%b at cycle %0d, not observed",
                   {pq[0].clr, pq[0].ferr, pq[0].trmt}, pq[0].cyc);
          void'(pq.pop_front());
        end
        dut_p = {clr_rx_rdy, frame_err, trmt};
        if (pq.size() > 0 && pq[0].cyc == cyc) begin
          pe = pq.pop_front();
          check("pulses{clr,ferr,trmt}", 32'(dut_p), 32'({pe.clr, pe.ferr, pe.trmt}));
          if (pe.trmt) check("tx_data", 32'(tx_data), 32'(RESP));
        end else if (dut_p != 3'b000) begin
          check("unexpected_pulse", 32'(dut_p), 32'h0);
        end

        while (sq.size() > 0 && sq[0].cyc < cyc) begin
          n_checks++; n_fail++;
          $display("FAIL state_missed: expected {cmd,rdy,busy}=%h at cycle %0d, not observed",
                   {sq[0].cmd, sq[0].rdy, sq[0].busy}, sq[0].cyc);
          void'(sq.pop_front());
        end
        dut_s = {cmd, cmd_rdy, resp_busy};
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
          se = sq.pop_front();
          check("state{cmd,rdy,busy}", 32'(dut_s), 32'({se.cmd, se.rdy, se.busy}));
        end else if (dut_s !== last_obs) begin
          check("unexpected_state_change", 32'(dut_s), 32'(last_obs));
        end
        last_obs = dut_s;
      end
    end
  end

  // UART transmitter stand-in: tx_done a few cycles after each trmt
  initial begin
    bit seen, was_rst;
    int cnt;
    tx_done = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      seen    = (trmt === 1'b1);
      was_rst = (rst === 1'b1);
      @(posedge clk);
      #1;
      tx_done = 1'b0;
      if (was_rst) cnt = 0;
      else if (seen) cnt = $urandom_range(tx_lat_hi, tx_lat_lo);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    @(posedge clk); #1;
    idle(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_cmd", 32'(cmd), 32'h0);
    check("reset_cmd_rdy", 32'(cmd_rdy), 32'h0);
    check("reset_resp_busy", 32'(resp_busy), 32'h0);
    check("reset_pulses", 32'({clr_rx_rdy, trmt, frame_err}), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'(RESP));
    tick();

    // Normal command and consumer clear
    send_byte(8'h20); send_byte(8'h7F); idle(2);
    pulse_clr(); idle(2);

    // Timeout then a fresh command
    send_byte(8'h40); idle(T + 4);
    send_byte(8'h41); send_byte(8'h02); idle(2);

    // Low byte on the exact timeout cycle completes the command
    send_byte(8'h11); idle(T - 1); send_byte(8'h22); idle(2);
    // One cycle later it is a new high byte
    send_byte(8'h55); idle(T); send_byte(8'h66); send_byte(8'h77); idle(2);
    // New high byte while cmd_rdy is set drops it, cmd held until the low byte
    send_byte(8'h33); idle(3); send_byte(8'h44); idle(2);

    // Completion and clear in the same cycle
    send_byte(8'h12);
    clr_cmd_rdy = 1'b1; send_byte(8'h34); clr_cmd_rdy = 1'b0;
    idle(2);

    // Response queueing with a slow transmitter
    tx_lat_lo = 6; tx_lat_hi = 6;
    send_resp = 1'b1; idle(3); send_resp = 1'b0;
    idle(20);

    // Reset while mid-command with a queued response
    send_byte(8'h5A);
    send_resp = 1'b1; idle(2); send_resp = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    idle(2);
    send_byte(8'h01); send_byte(8'h02); idle(3);

    // Random traffic
    tx_lat_lo = 1; tx_lat_hi = 4;
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 199);
      if (r == 0) begin
        rst = 1'b1; tick(); rst = 1'b0;
      end else if (r < 6) begin
        idle($urandom_range(10, 20));
      end else begin
        rx_rdy      = ($urandom_range(0, 3) == 0);
        rx_data     = 8'($urandom);
        clr_cmd_rdy = ($urandom_range(0, 7) == 0);
        send_resp   = ($urandom_range(0, 5) == 0);
        tick();
        rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
      end
    end

    idle(30);
    check("pulse_queue_drained", 32'(pq.size()), 32'h0);
    check("state_queue_drained", 32'(sq.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
